// File: rtl/benes_cfg_sequencer.sv
// Benes interconnect configuration sequencer: a register table of switch
// settings replayed onto the network, with result-valid aligned to its latency.
module benes_cfg_sequencer #(
   parameter int PORT_NUM    = 32,
   parameter int SWITCH_NUM  = PORT_NUM / 2,
   parameter int STAGE_NUM   = 2 * $clog2(PORT_NUM) - 1,
   parameter int CFG_DEPTH   = 16,
   parameter int NET_LATENCY = 12
) (
   input  logic                                    CLK,
   input  logic                                    RST_N,
   input  logic                                    I_CFG_WE,
   input  logic [$clog2(CFG_DEPTH)-1:0]            I_CFG_ADDR,
   input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]    I_CFG_MODULE_SEL,
   input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]    I_CFG_SLOT_SEL,
   input  logic [7:0]                              I_CFG_REPEAT,
   input  logic                                    I_START,
   input  logic [$clog2(CFG_DEPTH)-1:0]            I_START_ADDR,
   input  logic [$clog2(CFG_DEPTH):0]              I_COUNT,
   output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]    O_MODULE_SELECT,
   output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]    O_SLOT_SELECT,
   output logic                                    O_ISSUE_VALID,
   output logic                                    O_RESULT_VALID,
   output logic [$clog2(CFG_DEPTH)-1:0]            O_RESULT_TAG,
   output logic                                    O_BUSY,
   output logic                                    O_DONE,
   output logic                                    O_WR_REJECT
);

   localparam int AW = $clog2(CFG_DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] sel_t;

   sel_t       mod_tbl  [CFG_DEPTH];
   sel_t       slot_tbl [CFG_DEPTH];
   logic [7:0] rep_tbl  [CFG_DEPTH];

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   rem_q, rem_d;
   logic [7:0]    cnt_q, cnt_d;
   sel_t          mod_q, mod_d;
   sel_t          slot_q, slot_d;
   logic [7:0]    rep_q, rep_d;
   logic          rej_q;

   logic [NET_LATENCY-1:0] dv_q;
   logic [AW-1:0]          dt_q [NET_LATENCY];

   logic issue;
   logic last;
   logic wr_ok;

   assign issue = (state_q == S_RUN);
   assign last  = (rep_q == 8'd0) || (cnt_q == rep_q - 8'd1);
   assign wr_ok = I_CFG_WE && RST_N && (state_q == S_IDLE);

   // Table survives reset on purpose, so it has no reset branch.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mod_tbl[I_CFG_ADDR]  <= I_CFG_MODULE_SEL;
         slot_tbl[I_CFG_ADDR] <= I_CFG_SLOT_SEL;
         rep_tbl[I_CFG_ADDR]  <= I_CFG_REPEAT;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      mod_d   = mod_q;
      slot_d  = slot_q;
      rep_d   = rep_q;
      unique case (state_q)
         S_IDLE: begin
            if (I_START) begin
               ptr_d   = I_START_ADDR;
               rem_d   = I_COUNT;
               state_d = (I_COUNT == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            mod_d   = mod_tbl[ptr_q];
            slot_d  = slot_tbl[ptr_q];
            rep_d   = rep_tbl[ptr_q];
            cnt_d   = 8'd0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (last) begin
               // Next entry loads here so runs have no gap cycle.
               ptr_d  = ptr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               cnt_d  = 8'd0;
               mod_d  = mod_tbl[ptr_d];
               slot_d = slot_tbl[ptr_d];
               rep_d  = rep_tbl[ptr_d];
               if (rem_q == (AW + 1)'(1)) state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DRAIN: begin
            if (dv_q == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         mod_q   <= '0;
         slot_q  <= '0;
         rep_q   <= '0;
         rej_q   <= 1'b0;
         dv_q    <= '0;
         for (int i = 0; i < NET_LATENCY; i++) dt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         mod_q   <= mod_d;
         slot_q  <= slot_d;
         rep_q   <= rep_d;
         rej_q   <= I_CFG_WE && (state_q != S_IDLE);
         for (int i = NET_LATENCY - 1; i > 0; i--) begin
            dv_q[i] <= dv_q[i-1];
            dt_q[i] <= dt_q[i-1];
         end
         dv_q[0] <= issue;
         dt_q[0] <= issue ? ptr_q : '0;
      end
   end

   assign O_MODULE_SELECT = issue ? mod_q : '0;
   assign O_SLOT_SELECT   = issue ? slot_q : '0;
   assign O_ISSUE_VALID   = issue;
   assign O_RESULT_VALID  = dv_q[NET_LATENCY-1];
   assign O_RESULT_TAG    = dt_q[NET_LATENCY-1];
   assign O_BUSY          = (state_q != S_IDLE);
   assign O_DONE          = (state_q == S_DONE);
   assign O_WR_REJECT     = rej_q;

endmodule
